// File: rtl/ifetch_pkg.sv
// ifetch_pkg: shared fetch FSM states and instruction/ROM sizing constants
package ifetch_pkg;
  typedef enum logic [1:0] {BOOT = 2'd0, RUN = 2'd1, HALT = 2'd2, FAULT = 2'd3} fetch_state_t;
  localparam int INSTR_BYTES = 4;
  localparam int MEM_SIZE_DEFAULT = 1024;
endpackage

// File: rtl/ifetch_addr_chk.sv
// ifetch_addr_chk: combinational alignment and ROM-bounds check of a fetch address
module ifetch_addr_chk
  import ifetch_pkg::*;
#(
  parameter int MEM_SIZE = MEM_SIZE_DEFAULT
)(
  input  logic [63:0] pc,
  output logic        ok
);
  assign ok = (pc[1:0] == 2'b00) && (pc + 64'(INSTR_BYTES - 1) < 64'(MEM_SIZE));
endmodule

// File: rtl/ifetch_ctrl.sv
// ifetch_ctrl: single-stage instruction fetch with stall, redirect, halt and sticky fault.
// IFETCH_PERF_EN adds saturating fetch/stall/redirect counters.
module ifetch_ctrl
  import ifetch_pkg::*;
#(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter int          MEM_SIZE = MEM_SIZE_DEFAULT
)(
  input  logic        clk,
  input  logic        reset,
  output logic [63:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  input  logic        halt_req,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [63:0] if_pc,
  output logic        fault,
`ifdef IFETCH_PERF_EN
  output logic [31:0] fetch_cnt,
  output logic [31:0] stall_cnt,
  output logic [31:0] redirect_cnt,
`endif
  output logic [1:0]  state
);
  fetch_state_t state_q, state_d;
  logic [63:0] pc_q, pc_d, if_pc_q, if_pc_d;
  logic [31:0] if_instr_q, if_instr_d;
  logic        if_valid_q, if_valid_d, fault_q, fault_d;
  logic        pc_ok, run, redir, halt, hold, try_fetch, fetch, trap;
  ifetch_addr_chk #(.MEM_SIZE(MEM_SIZE)) u_chk (.pc(pc_q), .ok(pc_ok));
  assign run       = state_q == RUN;
  assign redir     = run && redirect_valid;
  assign halt      = run && !redirect_valid && halt_req;
  assign hold      = run && !redirect_valid && !halt_req && stall;
  assign try_fetch = run && !redirect_valid && !halt_req && !stall;
  assign fetch     = try_fetch && pc_ok;
  assign trap      = try_fetch && !pc_ok;
  // a halting cycle fetches nothing; the held instruction retires once decode takes it
  always_comb begin
    state_d    = state_q == BOOT ? RUN : (run && halt_req) ? HALT : trap ? FAULT : state_q;
    pc_d       = redir ? redirect_pc : fetch ? pc_q + 64'(INSTR_BYTES) : pc_q;
    if_valid_d = fetch ? 1'b1 : (redir || trap) ? 1'b0 :
                 (halt || state_q == HALT) ? if_valid_q & stall : if_valid_q;
    if_instr_d = fetch ? imem_instr : if_instr_q;
    if_pc_d    = fetch ? pc_q : if_pc_q;
    fault_d    = fault_q | trap;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= BOOT;
      pc_q       <= RESET_PC;
      if_valid_q <= 1'b0;
      if_instr_q <= '0;
      if_pc_q    <= '0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      if_valid_q <= if_valid_d;
      if_instr_q <= if_instr_d;
      if_pc_q    <= if_pc_d;
      fault_q    <= fault_d;
    end
  end
  assign imem_addr = pc_q;
  assign if_valid  = if_valid_q;
  assign if_instr  = if_instr_q;
  assign if_pc     = if_pc_q;
  assign fault     = fault_q;
  assign state     = state_q;
`ifdef IFETCH_PERF_EN
  logic [31:0] fetch_cnt_q, stall_cnt_q, redirect_cnt_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_cnt_q    <= '0;
      stall_cnt_q    <= '0;
      redirect_cnt_q <= '0;
    end else begin
      fetch_cnt_q    <= fetch_cnt_q + 32'(fetch && !(&fetch_cnt_q));
      stall_cnt_q    <= stall_cnt_q + 32'(hold && !(&stall_cnt_q));
      redirect_cnt_q <= redirect_cnt_q + 32'(redir && !(&redirect_cnt_q));
    end
  end
  assign fetch_cnt    = fetch_cnt_q;
  assign stall_cnt    = stall_cnt_q;
  assign redirect_cnt = redirect_cnt_q;
`endif
endmodule

// File: tb/tb_ifetch_ctrl.sv
// tb_ifetch_ctrl: directed vector table, perf sequence and randomized run against a behavioural fetch model
module tb_ifetch_ctrl;
  logic        clk = 1'b0;
  logic        reset, stall, redirect_valid, halt_req;
  logic [63:0] redirect_pc, imem_addr, if_pc;
  logic [31:0] imem_instr, if_instr;
  logic        if_valid, fault;
  logic [1:0]  state;
`ifdef IFETCH_PERF_EN
  logic [31:0] fetch_cnt, stall_cnt, redirect_cnt;
`endif
  logic [31:0] rom [256];
  int n_vec = 0;
  int n_err = 0;

  always #2500ps clk = ~clk;
  assign imem_instr = (imem_addr < 64'd1024) ? rom[imem_addr[9:2]] : 32'hDEAD_BEEF;

  ifetch_ctrl #(.RESET_PC(64'h0), .MEM_SIZE(1024)) dut (
    .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_instr(imem_instr),
    .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .halt_req(halt_req), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
    .fault(fault),
`ifdef IFETCH_PERF_EN
    .fetch_cnt(fetch_cnt), .stall_cnt(stall_cnt), .redirect_cnt(redirect_cnt),
`endif
    .state(state)
  );

  // behavioural model: state numbers are the documented debug encoding
  int unsigned m_s;
  logic [63:0] m_pc, m_ifpc;
  logic [31:0] m_instr;
  bit          m_v, m_f;
  longint unsigned m_fc, m_sc, m_rc;

  task automatic model(input bit r, st, rv, h, input logic [63:0] rpc);
    if (r) begin
      m_s = 0; m_pc = 0; m_ifpc = 0; m_instr = 0; m_v = 0; m_f = 0;
      m_fc = 0; m_sc = 0; m_rc = 0;
    end else if (m_s == 0) m_s = 1;
    else if (m_s == 1) begin
      if (rv) begin
        m_pc = rpc; m_v = 0; m_rc++;
        if (h) m_s = 2;
      end else if (h) begin
        m_s = 2;
        if (!st) m_v = 0;
      end else if (st) m_sc++;
      else if (m_pc % 4 != 0 || m_pc + 64'd3 >= 64'd1024) begin
        m_f = 1; m_v = 0; m_s = 3;
      end else begin
        m_instr = rom[m_pc[9:2]]; m_ifpc = m_pc; m_v = 1; m_pc = m_pc + 64'd4; m_fc++;
      end
    end else if (m_s == 2) begin
      if (!st) m_v = 0;
    end
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at vector %0d: got %h, want %h", nm, n_vec, act, exp);
    end
  endtask

  task automatic step(input bit r, st, rv, h, input logic [63:0] rpc);
    reset = r; stall = st; redirect_valid = rv; halt_req = h; redirect_pc = rpc;
    @(posedge clk);
    model(r, st, rv, h, rpc);
    #1;
    n_vec++;
  endtask

  typedef struct {
    bit rst, st, rv, h;
    logic [63:0] rpc;
    bit v;
    logic [63:0] ifpc, pc;
    logic [1:0] s;
    bit f;
  } vec_t;
  vec_t tbl[$];

  localparam logic [63:0] BIG = 64'hFFFF_FFFF_FFFF_FFFC;

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = $urandom;
    // rst st rv h rpc | v ifpc pc state fault
    tbl.push_back('{1,0,0,0,64'h0,   0,64'h0,64'h0,2'd0,0});
    tbl.push_back('{0,0,0,0,64'h0,   0,64'h0,64'h0,2'd1,0});
    tbl.push_back('{0,0,0,0,64'h0,   1,64'h0,64'h4,2'd1,0});
    tbl.push_back('{0,0,0,0,64'h0,   1,64'h4,64'h8,2'd1,0});
    tbl.push_back('{0,0,0,0,64'h0,   1,64'h8,64'hC,2'd1,0});
    tbl.push_back('{0,1,0,0,64'h0,   1,64'h8,64'hC,2'd1,0});
    tbl.push_back('{0,1,0,0,64'h0,   1,64'h8,64'hC,2'd1,0});
    tbl.push_back('{0,1,0,0,64'h0,   1,64'h8,64'hC,2'd1,0});
    tbl.push_back('{0,0,0,0,64'h0,   1,64'hC,64'h10,2'd1,0});
    tbl.push_back('{0,0,0,0,64'h0,   1,64'h10,64'h14,2'd1,0});
    tbl.push_back('{0,1,1,0,64'h40,  0,64'h10,64'h40,2'd1,0});
    tbl.push_back('{0,0,0,0,64'h0,   1,64'h40,64'h44,2'd1,0});
    tbl.push_back('{0,0,1,0,64'h3FE, 0,64'h40,64'h3FE,2'd1,0});
    tbl.push_back('{0,0,0,0,64'h0,   0,64'h40,64'h3FE,2'd3,1});
    tbl.push_back('{0,0,1,0,64'h0,   0,64'h40,64'h3FE,2'd3,1});
    tbl.push_back('{1,0,0,0,64'h0,   0,64'h0,64'h0,2'd0,0});
    tbl.push_back('{0,0,0,0,64'h0,   0,64'h0,64'h0,2'd1,0});
    tbl.push_back('{0,0,1,0,64'h400, 0,64'h0,64'h400,2'd1,0});
    tbl.push_back('{0,0,0,0,64'h0,   0,64'h0,64'h400,2'd3,1});
    tbl.push_back('{1,0,0,0,64'h0,   0,64'h0,64'h0,2'd0,0});
    tbl.push_back('{0,0,0,0,64'h0,   0,64'h0,64'h0,2'd1,0});
    tbl.push_back('{0,0,0,0,64'h0,   1,64'h0,64'h4,2'd1,0});
    tbl.push_back('{0,0,0,0,64'h0,   1,64'h4,64'h8,2'd1,0});
    tbl.push_back('{0,0,0,0,64'h0,   1,64'h8,64'hC,2'd1,0});
    tbl.push_back('{0,0,0,0,64'h0,   1,64'hC,64'h10,2'd1,0});
    tbl.push_back('{0,0,0,0,64'h0,   1,64'h10,64'h14,2'd1,0});
    tbl.push_back('{0,1,0,1,64'h0,   1,64'h10,64'h14,2'd2,0});
    tbl.push_back('{0,1,0,0,64'h0,   1,64'h10,64'h14,2'd2,0});
    tbl.push_back('{0,0,0,0,64'h0,   0,64'h10,64'h14,2'd2,0});
    tbl.push_back('{0,0,1,0,64'h80,  0,64'h10,64'h14,2'd2,0});
    tbl.push_back('{1,0,0,0,64'h0,   0,64'h0,64'h0,2'd0,0});
    tbl.push_back('{0,0,0,0,64'h0,   0,64'h0,64'h0,2'd1,0});
    tbl.push_back('{0,0,1,0,64'h3FC, 0,64'h0,64'h3FC,2'd1,0});
    tbl.push_back('{0,0,0,0,64'h0,   1,64'h3FC,64'h400,2'd1,0});
    tbl.push_back('{0,0,0,0,64'h0,   0,64'h3FC,64'h400,2'd3,1});
    tbl.push_back('{1,0,0,0,64'h0,   0,64'h0,64'h0,2'd0,0});
    tbl.push_back('{0,0,0,0,64'h0,   0,64'h0,64'h0,2'd1,0});
    tbl.push_back('{0,0,1,0,BIG,     0,64'h0,BIG,2'd1,0});
    tbl.push_back('{0,0,0,0,64'h0,   0,64'h0,BIG,2'd3,1});
    tbl.push_back('{1,0,0,0,64'h0,   0,64'h0,64'h0,2'd0,0});
    tbl.push_back('{0,0,0,0,64'h0,   0,64'h0,64'h0,2'd1,0});
    tbl.push_back('{0,0,0,0,64'h0,   1,64'h0,64'h4,2'd1,0});
    tbl.push_back('{0,0,1,1,64'h20,  0,64'h0,64'h20,2'd2,0});
    tbl.push_back('{0,0,0,0,64'h0,   0,64'h0,64'h20,2'd2,0});
    tbl.push_back('{1,0,0,0,64'h0,   0,64'h0,64'h0,2'd0,0});
    foreach (tbl[i]) begin
      step(tbl[i].rst, tbl[i].st, tbl[i].rv, tbl[i].h, tbl[i].rpc);
      chk("tbl.state", 64'(state), 64'(tbl[i].s));
      chk("tbl.if_valid", 64'(if_valid), 64'(tbl[i].v));
      chk("tbl.if_pc", if_pc, tbl[i].ifpc);
      chk("tbl.imem_addr", imem_addr, tbl[i].pc);
      chk("tbl.fault", 64'(fault), 64'(tbl[i].f));
      if (tbl[i].v) chk("tbl.if_instr", 64'(if_instr), 64'(rom[tbl[i].ifpc[9:2]]));
      if (tbl[i].rst) chk("tbl.if_instr_rst", 64'(if_instr), 64'h0);
    end
`ifdef IFETCH_PERF_EN
    step(1, 0, 0, 0, 0);
    chk("perf.fetch_rst", 64'(fetch_cnt), 64'd0);
    step(0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0);
    step(0, 0, 1, 0, 64'h40);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0);
    chk("perf.fetch_cnt", 64'(fetch_cnt), 64'd10);
    chk("perf.stall_cnt", 64'(stall_cnt), 64'd3);
    chk("perf.redirect_cnt", 64'(redirect_cnt), 64'd1);
`endif
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      bit r, st, rv, h;
      logic [63:0] rpc;
      int k;
      r  = $urandom_range(0, 99) < 2;
      st = $urandom_range(0, 99) < 30;
      rv = $urandom_range(0, 99) < 10;
      h  = $urandom_range(0, 99) < 3;
      k  = $urandom_range(0, 9);
      rpc = k < 7 ? 64'($urandom_range(0, 255)) * 64'd4 :
            k == 7 ? 64'h3FE : k == 8 ? 64'h400 : {32'($urandom), 32'($urandom)};
      step(r, st, rv, h, rpc);
      chk("rnd.state", 64'(state), 64'(m_s));
      chk("rnd.if_valid", 64'(if_valid), 64'(m_v));
      chk("rnd.if_pc", if_pc, m_ifpc);
      chk("rnd.imem_addr", imem_addr, m_pc);
      chk("rnd.fault", 64'(fault), 64'(m_f));
      chk("rnd.if_instr", 64'(if_instr), 64'(m_instr));
`ifdef IFETCH_PERF_EN
      chk("rnd.fetch_cnt", 64'(fetch_cnt), m_fc);
      chk("rnd.stall_cnt", 64'(stall_cnt), m_sc);
      chk("rnd.redirect_cnt", 64'(redirect_cnt), m_rc);
`endif
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/ifetch_ctrl.md
IFETCH_CTRL -- requirements
Module: ifetch_ctrl

Interface
REQ-001 SHALL have parameter RESET_PC, default 64'h0, meaning the PC loaded on reset.
REQ-002 SHALL have parameter MEM_SIZE, default 1024, meaning the instruction ROM size in bytes (power of two, >4).
REQ-003 SHALL have one clock and a synchronous, active-high reset; all state updates on posedge clk.
REQ-004 SHALL have ports:
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- imem_addr  out  64  byte address to instruction ROM (combinational read)
- imem_instr  in  32  ROM read data for imem_addr
- stall  in  1  decode stage cannot accept; hold fetch
- redirect_valid  in  1  branch/jump taken this cycle
- redirect_pc  in  64  branch target
- halt_req  in  1  stop fetching after current cycle
- if_valid  out  1  if_instr/if_pc hold a live instruction
- if_instr  out  32  fetched instruction (IF/ID latch)
- if_pc  out  64  PC of if_instr
- fault  out  1  sticky misaligned/out-of-bounds fetch flag
- state  out  2  current FSM state (debug)

Function
REQ-005 SHALL drive imem_addr = pc register, combinationally, every cycle.
REQ-006 SHALL implement FSM states BOOT, RUN, HALT, FAULT.
REQ-007 BOOT SHALL last exactly one cycle after reset deassert, with if_valid=0, then go to RUN.
REQ-008 In RUN, with no stall/redirect/fault: latch if_instr=imem_instr, if_pc=pc, if_valid=1, pc+=4 each cycle (one-cycle fetch latency).
REQ-009 In RUN with stall=1 and redirect_valid=0: pc, if_instr, if_pc, if_valid SHALL hold unchanged.
REQ-010 redirect_valid=1 SHALL take priority over stall: pc<=redirect_pc, if_valid<=0 (flush) next cycle.
REQ-011 Before fetching, pc SHALL be checked: pc[1:0]!=0 or pc+3>=MEM_SIZE -> no latch, if_valid<=0, fault<=1, state<=FAULT.
REQ-012 A redirect_pc that is misaligned/out of bounds SHALL fault on the following fetch cycle, not on the redirect cycle.
REQ-013 FAULT SHALL be absorbing until reset; fault stays 1, if_valid stays 0, pc holds.
REQ-014 halt_req=1 in RUN (no redirect) SHALL go to HALT; the already-latched instruction stays valid until consumed (stall=0) then if_valid<=0.
REQ-015 HALT SHALL be absorbing until reset; pc holds; redirect_valid ignored.
REQ-016 Simultaneous halt_req and redirect_valid: redirect applied to pc, then HALT; if_valid<=0.
REQ-017 pc+4 SHALL wrap modulo 2^64; bounds check catches it before any fetch.
REQ-018 state encoding: BOOT=0, RUN=1, HALT=2, FAULT=3.

Reset
REQ-019 reset=1 at any clock edge, including mid-stall or in FAULT/HALT, SHALL set pc=RESET_PC, state=BOOT, if_valid=0, if_instr=0, if_pc=0, fault=0 and clear perf counters.

Configuration
REQ-020 Macro IFETCH_PERF_EN defined: SHALL add outputs fetch_cnt, stall_cnt, redirect_cnt (32 bits each, saturating at all-ones) counting RUN-state latches, stall-hold cycles and redirects.
REQ-021 Macro IFETCH_PERF_EN undefined: those ports and counters SHALL not exist; all other behaviour identical.

Structure
REQ-022 Shared package ifetch_pkg SHALL hold the fetch_state_t enum, INSTR_BYTES=4 and the default MEM_SIZE constant.
REQ-023 Bounds/alignment check SHALL be one sub-module, ifetch_addr_chk (pc, MEM_SIZE -> ok), combinational.
REQ-024 Bench SHALL instantiate ifetch_ctrl with the existing instruction ROM on a 5000 ps clock period.

Verification
REQ-025 Reset, 4 free-run cycles -> if_pc sequence 0,4,8,12 after BOOT cycle; if_valid=1 from cycle 2.
REQ-026 stall=1 for 3 cycles at if_pc=8 -> if_pc/if_instr hold 8 for 3 cycles, pc stays 12; resumes 12,16.
REQ-027 redirect_valid=1, redirect_pc=0x40 while stall=1 -> next cycle if_valid=0, then if_pc=0x40.
REQ-028 redirect_pc=0x3FE -> one cycle later fault=1, state=FAULT, if_valid=0; stays until reset; redirect_pc=0x400 also faults.
REQ-029 halt_req at if_pc=0x10 -> state=HALT, if_valid drops after stall=0, pc frozen; reset returns to BOOT with pc=0.
REQ-030 With IFETCH_PERF_EN: 10 fetches, 3 stall cycles, 1 redirect -> fetch_cnt=10, stall_cnt=3, redirect_cnt=1.
